// File: rtl/reg_pkg.sv
// Shared definitions for both ends of the LSB-first register link.
// Both ends use it so they agree on word width and counter sizing.
package reg_pkg;

  localparam int DATA_W = 8;

  // Minimum bits needed to count 0..n-1. Never returns less than 1.
  function automatic int clog2(input int n);
    int v;
    int r;
    v = (n > 1) ? n - 1 : 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up-counter with synchronous clear.
// o_wrap pulses on the increment that returns the count to zero.
import reg_pkg::*;

module mod_counter #(
  parameter int MOD = DATA_W,
  parameter int CW  = clog2(MOD)
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_inc,
  input  logic          i_clr,
  output logic [CW-1:0] o_cnt,
  output logic          o_tc,
  output logic          o_wrap
);

  logic [CW-1:0] r_cnt;
  logic          w_tc;

  assign w_tc   = (r_cnt == CW'(MOD - 1));
  assign o_cnt  = r_cnt;
  assign o_tc   = w_tc;
  assign o_wrap = i_inc && w_tc && !i_clr;

  // Clear takes priority over increment.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= w_tc ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/deser_8bit.sv
// LSB-first serial-to-parallel receiver with a valid/ready holding register.
// The shift register keeps filling while q is occupied; only the final bit stalls.
import reg_pkg::*;

module deser_8bit #(
  parameter int WIDTH = DATA_W,
  parameter int CW    = clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             s_in,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic [CW-1:0]    bit_cnt
);

  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_q;
  logic             r_q_valid;
  logic [WIDTH-1:0] w_sr_next;
  logic [CW-1:0]    w_cnt;
  logic             w_tc;
  logic             w_accept;
  logic             w_complete;
  logic             w_drain;
  logic             w_s_ready;

  // Only the completing bit needs a free holding register; a same-edge drain frees it.
  assign w_s_ready  = !(w_tc && r_q_valid && !q_ready);
  assign w_accept   = s_valid && w_s_ready && !clr;
  assign w_drain    = r_q_valid && q_ready;
  assign w_sr_next  = {s_in, r_sr[WIDTH-1:1]};

  mod_counter #(
    .MOD (WIDTH),
    .CW  (CW)
  ) u_bit_cnt (
    .i_clock (clock),
    .i_reset (reset),
    .i_inc   (w_accept),
    .i_clr   (clr),
    .o_cnt   (w_cnt),
    .o_tc    (w_tc),
    .o_wrap  (w_complete)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sr <= '0;
    end else if (clr) begin
      r_sr <= '0;
    end else if (w_accept) begin
      r_sr <= w_sr_next;
    end
  end

  // A completing bit wins over a drain, so back-to-back words never leave a bubble.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_q       <= '0;
      r_q_valid <= 1'b0;
    end else if (w_complete) begin
      r_q       <= w_sr_next;
      r_q_valid <= 1'b1;
    end else if (w_drain) begin
      r_q_valid <= 1'b0;
    end
  end

  assign s_ready = w_s_ready;
  assign q       = r_q;
  assign q_valid = r_q_valid;
  assign bit_cnt = w_cnt;

endmodule

// File: tb/tb_deser_8bit.sv
// Directed bench for deser_8bit: words expected at drain time are queued by the
// stimulus thread and checked by an independent monitor on each q handshake.
module tb_deser_8bit;

  logic       clock;
  logic       reset;
  logic       clr;
  logic       s_in;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] q;
  logic       q_valid;
  logic       q_ready;
  logic [2:0] bit_cnt;

  int checks;
  int failures;
  int s_ready_drops;
  logic [7:0] exp_q[$];

  deser_8bit dut (
    .clock   (clock),
    .reset   (reset),
    .clr     (clr),
    .s_in    (s_in),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .q       (q),
    .q_valid (q_valid),
    .q_ready (q_ready),
    .bit_cnt (bit_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: a word is consumed at the edge following a cycle with q_valid && q_ready.
  always @(negedge clock) begin
    if (!reset && q_valid === 1'b1 && q_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", {24'd0, q}, 32'hDEAD);
      end else begin
        check("drained_word", {24'd0, q}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // Inputs change 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b);
    s_valid = 1'b1;
    s_in    = b;
    if (s_ready !== 1'b1) s_ready_drops = s_ready_drops + 1;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    logic [7:0] v;
    v = w;
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic drain_one();
    q_ready = 1'b1;
    s_valid = 1'b0;
    tick();
    q_ready = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w3c;
    checks = 0;
    failures = 0;
    s_ready_drops = 0;
    reset = 1'b1; clr = 1'b0; s_in = 1'b0; s_valid = 1'b0; q_ready = 1'b0;
    #12;
    reset = 1'b0;
    tick();

    // 1. reset values, then 0xA5 LSB first
    check("rst_q", {24'd0, q}, 32'h00);
    check("rst_q_valid", {31'd0, q_valid}, 32'd0);
    check("rst_bit_cnt", {29'd0, bit_cnt}, 32'd0);
    check("rst_s_ready", {31'd0, s_ready}, 32'd1);
    exp_q.push_back(8'hA5);
    send_word(8'hA5);
    check("t1_q", {24'd0, q}, 32'hA5);
    check("t1_q_valid", {31'd0, q_valid}, 32'd1);
    check("t1_bit_cnt", {29'd0, bit_cnt}, 32'd0);

    // 2. backpressure on the last bit of 0x3C, then simultaneous drain + load
    w3c = 8'h3C;
    for (int i = 0; i < 7; i++) send_bit(w3c[i]);
    check("t2_bit_cnt7", {29'd0, bit_cnt}, 32'd7);
    s_valid = 1'b1;
    s_in    = w3c[7];
    #1;
    check("t2_stall_s_ready", {31'd0, s_ready}, 32'd0);
    tick();
    check("t2_stall_cnt", {29'd0, bit_cnt}, 32'd7);
    check("t2_stall_q", {24'd0, q}, 32'hA5);
    exp_q.push_back(8'h3C);
    q_ready = 1'b1;
    #1;
    check("t2_unstall_s_ready", {31'd0, s_ready}, 32'd1);
    tick();
    s_valid = 1'b0;
    check("t2_swap_q", {24'd0, q}, 32'h3C);
    check("t2_swap_q_valid", {31'd0, q_valid}, 32'd1);
    check("t2_swap_cnt", {29'd0, bit_cnt}, 32'd0);
    tick();
    q_ready = 1'b0;
    check("t2_drained", {31'd0, q_valid}, 32'd0);

    // 3. clr discards a partial word and the clr-cycle bit
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    check("t3_cnt4", {29'd0, bit_cnt}, 32'd4);
    clr = 1'b1; s_valid = 1'b1; s_in = 1'b1;
    tick();
    clr = 1'b0; s_valid = 1'b0;
    check("t3_clr_cnt", {29'd0, bit_cnt}, 32'd0);
    check("t3_clr_q_valid", {31'd0, q_valid}, 32'd0);
    exp_q.push_back(8'h80);
    send_word(8'h80);
    check("t3_q", {24'd0, q}, 32'h80);
    drain_one();

    // 4. async reset between edges with a held word and 5 bits collected
    send_word(8'h11);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    check("t4_pre_q_valid", {31'd0, q_valid}, 32'd1);
    check("t4_pre_cnt", {29'd0, bit_cnt}, 32'd5);
    #2;
    reset = 1'b1;
    #1;
    check("t4_rst_q", {24'd0, q}, 32'h00);
    check("t4_rst_q_valid", {31'd0, q_valid}, 32'd0);
    check("t4_rst_cnt", {29'd0, bit_cnt}, 32'd0);
    #1;
    reset = 1'b0;
    tick();
    check("t4_s_ready", {31'd0, s_ready}, 32'd1);

    // 5. continuous stream with the consumer always ready
    q_ready = 1'b1;
    s_ready_drops = 0;
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h5A);
    send_word(8'hFF);
    check("t5_w0", {24'd0, q}, 32'hFF);
    send_word(8'h00);
    check("t5_w1", {24'd0, q}, 32'h00);
    send_word(8'h5A);
    check("t5_w2", {24'd0, q}, 32'h5A);
    check("t5_w2_valid", {31'd0, q_valid}, 32'd1);
    tick();
    q_ready = 1'b0;
    check("t5_s_ready_drops", s_ready_drops, 0);
    check("t5_idle_q_valid", {31'd0, q_valid}, 32'd0);

    // 6. s_valid toggling: 0x81 needs 16 cycles
    exp_q.push_back(8'h81);
    for (int i = 0; i < 8; i++) begin
      send_bit((i == 0 || i == 7) ? 1'b1 : 1'b0);
      if (i == 3) check("t6_mid_cnt", {29'd0, bit_cnt}, 32'd4);
      tick();
    end
    check("t6_q", {24'd0, q}, 32'h81);
    check("t6_q_valid", {31'd0, q_valid}, 32'd1);
    check("t6_cnt", {29'd0, bit_cnt}, 32'd0);
    drain_one();

    tick();
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
